line_loader: RTL and testbench
==============================

// Module: line_loader
// PURPOSE
// - Host-side producer for the edge-function array: receives a byte-stream scene packet (threshold + NUM_LINES lines),
//   assembles it in a shadow bank, commits it atomically to the active bank on frame start.
// - Active bank drives my_line/my_thresh of every edge_function instance; committing only at frame start prevents tearing.
// PARAMETERS
// - NUM_LINES   12    lines per packet / edge_function instances fed
// - LINE_BITS   8     coordinate width (<= 8); one byte per coordinate, upper byte bits ignored if LINE_BITS < 8
// - THRESH_BITS 8     threshold width (<= 8); one byte
// - TIMEOUT     1023  max idle cycles between accepted bytes inside a packet
// - HEADER      8'hA5 packet sync byte
// PORTS
// - clk_i      in   1                          clock; all logic on posedge
// - rst_i      in   1                          synchronous reset, active-high
// - data_i     in   8                          stream byte
// - valid_i    in   1                          data_i valid
// - ready_o    out  1                          loader can accept; byte transfers when valid_i && ready_o
// - frame_start_i in 1                         one-cycle pulse at start of frame (vsync)
// - lines_o    out  NUM_LINES*4*LINE_BITS      active bank; line k at [k*4*LINE_BITS +: 4*LINE_BITS], packed {x0,y0,x1,y1}
// - thresh_o   out  THRESH_BITS                active threshold
// - updated_o  out  1                          one-cycle pulse: active bank committed
// - error_o    out  1                          one-cycle pulse: packet aborted by timeout
// BEHAVIOUR
// - Reset: state IDLE, lines_o=0, thresh_o=0, shadow=0, counters=0, updated_o=0, error_o=0; ready_o=0 while rst_i high.
// - Packet: HEADER, thresh byte, then per line k=0..NUM_LINES-1 bytes x0,y0,x1,y1 (4*NUM_LINES+2 bytes total).
// - ready_o = 1 in IDLE/THRESH/COORDS, 0 in PENDING (combinational from state).
// - FSM: IDLE: accepted byte == HEADER -> THRESH; other bytes accepted and dropped.
//   THRESH: accepted byte -> shadow thresh (low THRESH_BITS), coord index=0 -> COORDS.
//   COORDS: accepted byte -> shadow coord[index], index++; byte with index==4*NUM_LINES-1 -> PENDING.
//   PENDING: frame_start_i -> copy shadow to lines_o/thresh_o on same edge, updated_o=1 next cycle, -> IDLE.
// - Commit latency: lines_o/thresh_o change on the clock edge sampling frame_start_i in PENDING; visible next cycle.
// - frame_start_i outside PENDING: ignored, active bank unchanged (partial packets never become visible).
// - Final coordinate byte and frame_start_i in same cycle: enter PENDING only; commit waits for next frame_start_i.
// - Timeout: in THRESH/COORDS, gap counter counts cycles without an accepted byte, cleared on each accept;
//   counter reaching TIMEOUT -> IDLE, error_o pulse, index reset, active bank untouched. No timeout in IDLE/PENDING.
// - HEADER value inside THRESH/COORDS is payload, not a resync.
// - rst_i mid-packet or in PENDING: discard shadow, restore reset values incl. active bank.
// - Coordinate index width $clog2(4*NUM_LINES); gap counter width $clog2(TIMEOUT+1); no wrap possible.
// TESTING
// - Reset: hold rst_i 2 cycles -> lines_o=0, thresh_o=0, ready_o=0 during, ready_o=1 after, no pulses.
// - Full packet A5,10,{k,k+1,k+2,k+3} per line, then frame_start_i -> thresh_o=8'h10, line 0 = {0,1,2,3}, updated_o one pulse.
// - frame_start_i mid-packet then rest of packet -> no change until next frame_start_i; then commit.
// - Backpressure: packet done, hold valid_i 20 cycles -> ready_o=0, no byte consumed until after commit.
// - Timeout (TIMEOUT=16): header + 5 bytes, stall 16 cycles -> error_o pulse, IDLE, old bank retained.
// - Bytes 00,FF before HEADER dropped; last byte and frame_start_i same cycle -> commit at following frame_start_i only.

Source files
------------

// File: rtl/line_loader.sv
// Scene packet loader: assembles threshold + NUM_LINES line coordinates from a byte stream
// into a shadow bank and commits it to the active bank only on frame start.
module line_loader #(
    parameter int unsigned NUM_LINES   = 12,
    parameter int unsigned LINE_BITS   = 8,
    parameter int unsigned THRESH_BITS = 8,
    parameter int unsigned TIMEOUT     = 1023,
    parameter logic [7:0]  HEADER      = 8'hA5
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [7:0]                       data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             frame_start_i,
    output logic [NUM_LINES*4*LINE_BITS-1:0] lines_o,
    output logic [THRESH_BITS-1:0]           thresh_o,
    output logic                             updated_o,
    output logic                             error_o
);

    localparam int unsigned NUM_COORDS = 4 * NUM_LINES;
    localparam int unsigned IDX_W      = $clog2(NUM_COORDS);
    localparam int unsigned GAP_W      = $clog2(TIMEOUT + 1);
    localparam int unsigned OFF_W      = $clog2(NUM_COORDS * LINE_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_COORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        THRESH,
        COORDS,
        PENDING
    } state_t;

    state_t state, state_next;

    logic                             accept;
    logic                             load_thresh;
    logic                             load_coord;
    logic                             commit;
    logic                             timeout;
    logic [IDX_W-1:0]                 coord_idx;
    logic [GAP_W-1:0]                 gap_cnt;
    logic [OFF_W-1:0]                 coord_off;
    logic [NUM_LINES*4*LINE_BITS-1:0] shadow_lines;
    logic [THRESH_BITS-1:0]           shadow_thresh;

    // Coordinate 4k+j lands at slot 4k+(3-j) so that x0 ends up in the line's MSBs.
    assign coord_off = OFF_W'(int'(coord_idx ^ IDX_W'(3)) * LINE_BITS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ready_o     = (state != PENDING) && !rst_i;
        accept      = valid_i && ready_o;
        load_thresh = 1'b0;
        load_coord  = 1'b0;
        commit      = 1'b0;
        timeout     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && data_i == HEADER) begin
                    state_next = THRESH;
                end
            end
            THRESH: begin
                if (accept) begin
                    load_thresh = 1'b1;
                    state_next  = COORDS;
                end else if (gap_cnt == GAP_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            COORDS: begin
                if (accept) begin
                    load_coord = 1'b1;
                    if (coord_idx == LAST_IDX) begin
                        state_next = PENDING;
                    end
                end else if (gap_cnt == GAP_LIMIT) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            PENDING: begin
                if (frame_start_i) begin
                    commit     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lines_o       <= '0;
            thresh_o      <= '0;
            shadow_lines  <= '0;
            shadow_thresh <= '0;
            coord_idx     <= '0;
            gap_cnt       <= '0;
            updated_o     <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            updated_o <= commit;
            error_o   <= timeout;

            if ((state == THRESH || state == COORDS) && !accept && !timeout) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end

            if (load_thresh) begin
                shadow_thresh <= data_i[THRESH_BITS-1:0];
                coord_idx     <= '0;
            end

            if (load_coord) begin
                shadow_lines[coord_off +: LINE_BITS] <= data_i[LINE_BITS-1:0];
                coord_idx <= (coord_idx == LAST_IDX) ? '0 : coord_idx + 1'b1;
            end

            if (timeout) begin
                coord_idx <= '0;
            end

            if (commit) begin
                lines_o  <= shadow_lines;
                thresh_o <= shadow_thresh;
            end
        end
    end

endmodule

// File: tb/tb_line_loader.sv
// Randomized bench for line_loader: a byte-level packet model predicts the active bank
// after each frame start, with scenarios for backpressure, timeout and reset.
module tb_line_loader;

    localparam int NL = 12;
    localparam int LB = 8;
    localparam int TO = 16;
    localparam int NB = 4 * NL;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [7:0]        data_i;
    logic              valid_i;
    logic              ready_o;
    logic              frame_start_i;
    logic [NL*4*LB-1:0] lines_o;
    logic [7:0]        thresh_o;
    logic              updated_o;
    logic              error_o;

    line_loader #(
        .NUM_LINES  (NL),
        .LINE_BITS  (LB),
        .THRESH_BITS(8),
        .TIMEOUT    (TO),
        .HEADER     (8'hA5)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .frame_start_i(frame_start_i),
        .lines_o      (lines_o),
        .thresh_o     (thresh_o),
        .updated_o    (updated_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;
    int send_to = 0;
    int err_cnt = 0;

    logic [7:0] exp_bytes [NB];
    logic [7:0] exp_thresh;
    logic [7:0] pkt [NB];
    logic [7:0] pkt_th;

    always @(posedge clk_i) if (error_o === 1'b1) err_cnt++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Active bank as the byte model says it should appear: line k = {x0,y0,x1,y1}.
    function automatic logic [NL*4*LB-1:0] exp_vec();
        logic [NL*4*LB-1:0] v;
        for (int k = 0; k < NL; k++)
            v[k*32 +: 32] = {exp_bytes[4*k], exp_bytes[4*k+1], exp_bytes[4*k+2], exp_bytes[4*k+3]};
        return v;
    endfunction

    function automatic logic [7:0] pbyte(input int i);
        if (i == 0) return 8'hA5;
        if (i == 1) return pkt_th;
        return pkt[i-2];
    endfunction

    task automatic rand_packet();
        pkt_th = 8'($urandom);
        for (int i = 0; i < NB; i++) pkt[i] = 8'($urandom);
        pkt[$urandom_range(NB-1, 0)] = 8'hA5;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fs);
        bit acc;
        acc = 1'b0;
        data_i = b;
        valid_i = 1'b1;
        frame_start_i = fs;
        for (int n = 0; n < 64 && !acc; n++) begin
            acc = (ready_o === 1'b1);
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        frame_start_i = 1'b0;
        if (!acc) send_to++;
    endtask

    task automatic send_range(input int first, input int last, input int max_gap, input bit fs_last);
        for (int i = first; i <= last; i++) begin
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk_i);
            send_byte(pbyte(i), fs_last && (i == last));
        end
    endtask

    task automatic frame_pulse(output logic u0, output logic u1);
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        u0 = updated_o;
        @(negedge clk_i);
        u1 = updated_o;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready_during: got %b expected 0", ready_o); else passes++;
        @(negedge clk_i);
        checks++; if (ready_o !== 1'b0) $display("FAIL reset_ready_during2: got %b expected 0", ready_o); else passes++;
        rst_i = 1'b0;
        for (int i = 0; i < NB; i++) exp_bytes[i] = 8'h00;
        exp_thresh = 8'h00;
        #1;
        checks++; if (ready_o !== 1'b1) $display("FAIL reset_ready_after: got %b expected 1", ready_o); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL reset_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (thresh_o !== 8'h00) $display("FAIL reset_thresh: got %h expected 00", thresh_o); else passes++;
        checks++; if ({updated_o, error_o} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {updated_o, error_o}); else passes++;
        @(negedge clk_i);
    endtask

    task automatic test_full_packet();
        logic u0, u1;
        int to0;
        to0 = send_to;
        pkt_th = 8'h10;
        for (int k = 0; k < NL; k++)
            for (int j = 0; j < 4; j++) pkt[4*k+j] = 8'(k + j);
        send_range(0, NB + 1, 0, 1'b0);
        checks++; if (ready_o !== 1'b0) $display("FAIL full_pending_ready: got %b expected 0", ready_o); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL full_precommit_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if ({u0, u1} !== 2'b10) $display("FAIL full_updated: got %b expected 10", {u0, u1}); else passes++;
        checks++; if (thresh_o !== 8'h10) $display("FAIL full_thresh: got %h expected 10", thresh_o); else passes++;
        checks++; if (lines_o[31:0] !== 32'h00010203) $display("FAIL full_line0: got %h expected 00010203", lines_o[31:0]); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL full_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (send_to !== to0) $display("FAIL full_send_stall: got %0d expected %0d", send_to, to0); else passes++;
    endtask

    task automatic test_mid_frame();
        logic u0, u1;
        rand_packet();
        send_range(0, 10, 0, 1'b0);
        frame_pulse(u0, u1);
        checks++; if ({u0, u1} !== 2'b00) $display("FAIL mid_no_update: got %b expected 00", {u0, u1}); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL mid_lines_held: got %h expected %h", lines_o, exp_vec()); else passes++;
        send_range(11, NB + 1, 0, 1'b0);
        checks++; if (thresh_o !== exp_thresh) $display("FAIL mid_thresh_held: got %h expected %h", thresh_o, exp_thresh); else passes++;
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if (u0 !== 1'b1) $display("FAIL mid_updated: got %b expected 1", u0); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL mid_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (thresh_o !== exp_thresh) $display("FAIL mid_thresh: got %h expected %h", thresh_o, exp_thresh); else passes++;
    endtask

    task automatic test_random_packets();
        logic u0, u1;
        logic [7:0] g;
        int e0;
        e0 = err_cnt;
        for (int it = 0; it < 4; it++) begin
            rand_packet();
            repeat ($urandom_range(3, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, 1'b0);
            end
            send_range(0, NB + 1, TO - 4, 1'b0);
            repeat ($urandom_range(5, 0)) @(negedge clk_i);
            frame_pulse(u0, u1);
            exp_bytes = pkt;
            exp_thresh = pkt_th;
            checks++; if (u0 !== 1'b1) $display("FAIL rand_updated[%0d]: got %b expected 1", it, u0); else passes++;
            checks++; if (lines_o !== exp_vec()) $display("FAIL rand_lines[%0d]: got %h expected %h", it, lines_o, exp_vec()); else passes++;
            checks++; if (thresh_o !== exp_thresh) $display("FAIL rand_thresh[%0d]: got %h expected %h", it, thresh_o, exp_thresh); else passes++;
        end
        checks++; if (err_cnt !== e0) $display("FAIL rand_no_timeout: got %0d errors expected %0d", err_cnt, e0); else passes++;
    endtask

    task automatic test_backpressure();
        logic u0, u1;
        int rdy_hi;
        rand_packet();
        send_range(0, NB + 1, 0, 1'b0);
        rdy_hi = 0;
        data_i = 8'hA5;
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (ready_o !== 1'b0) rdy_hi++;
            @(negedge clk_i);
        end
        checks++; if (rdy_hi !== 0) $display("FAIL bp_ready_low: got %0d ready cycles expected 0", rdy_hi); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL bp_lines_held: got %h expected %h", lines_o, exp_vec()); else passes++;
        frame_start_i = 1'b1;
        @(negedge clk_i);
        frame_start_i = 1'b0;
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if (updated_o !== 1'b1) $display("FAIL bp_updated: got %b expected 1", updated_o); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL bp_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        // Held header byte is taken right after the commit; the rest follows without a header.
        @(negedge clk_i);
        valid_i = 1'b0;
        rand_packet();
        send_range(1, NB + 1, 0, 1'b0);
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if (u0 !== 1'b1) $display("FAIL bp_held_header_updated: got %b expected 1", u0); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL bp_held_header_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
    endtask

    task automatic test_same_cycle();
        logic u0, u1;
        rand_packet();
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_range(0, NB + 1, 0, 1'b1);
        checks++; if (updated_o !== 1'b0) $display("FAIL same_no_update: got %b expected 0", updated_o); else passes++;
        checks++; if (ready_o !== 1'b0) $display("FAIL same_pending: got %b expected 0", ready_o); else passes++;
        repeat (3) @(negedge clk_i);
        checks++; if (lines_o !== exp_vec()) $display("FAIL same_lines_held: got %h expected %h", lines_o, exp_vec()); else passes++;
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if ({u0, u1} !== 2'b10) $display("FAIL same_updated: got %b expected 10", {u0, u1}); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL same_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (thresh_o !== exp_thresh) $display("FAIL same_thresh: got %h expected %h", thresh_o, exp_thresh); else passes++;
    endtask

    task automatic test_timeout();
        logic u0, u1;
        int first, pulses;
        rand_packet();
        send_range(0, 5, 0, 1'b0);
        first = -1;
        pulses = 0;
        for (int i = 1; i <= TO + 4; i++) begin
            @(negedge clk_i);
            if (error_o === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++; if (pulses !== 1) $display("FAIL to_pulse_count: got %0d expected 1", pulses); else passes++;
        checks++; if (first < TO || first > TO + 1) $display("FAIL to_pulse_time: got %0d expected %0d..%0d", first, TO, TO + 1); else passes++;
        checks++; if (ready_o !== 1'b1) $display("FAIL to_idle_ready: got %b expected 1", ready_o); else passes++;
        frame_pulse(u0, u1);
        checks++; if ({u0, u1} !== 2'b00) $display("FAIL to_no_update: got %b expected 00", {u0, u1}); else passes++;
        checks++; if (lines_o !== exp_vec()) $display("FAIL to_lines_kept: got %h expected %h", lines_o, exp_vec()); else passes++;
        rand_packet();
        send_range(0, NB + 1, 0, 1'b0);
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if (lines_o !== exp_vec()) $display("FAIL to_recover_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
    endtask

    task automatic test_reset_mid();
        logic u0, u1;
        rand_packet();
        send_range(0, 20, 0, 1'b0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < NB; i++) exp_bytes[i] = 8'h00;
        exp_thresh = 8'h00;
        #1;
        checks++; if (lines_o !== exp_vec()) $display("FAIL rstmid_lines: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (thresh_o !== 8'h00) $display("FAIL rstmid_thresh: got %h expected 00", thresh_o); else passes++;
        @(negedge clk_i);
        rand_packet();
        send_range(0, NB + 1, 0, 1'b0);
        frame_pulse(u0, u1);
        exp_bytes = pkt;
        exp_thresh = pkt_th;
        checks++; if (lines_o !== exp_vec()) $display("FAIL rstmid_recover: got %h expected %h", lines_o, exp_vec()); else passes++;
        checks++; if (send_to !== 0) $display("FAIL send_stalls: got %0d expected 0", send_to); else passes++;
    endtask

    initial begin
        rst_i = 1'b1;
        valid_i = 1'b0;
        data_i = 8'h00;
        frame_start_i = 1'b0;
        test_reset();
        test_full_packet();
        test_mid_frame();
        test_random_packets();
        test_backpressure();
        test_same_cycle();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
